// File: rtl/spi_cs_arbiter.sv
// spi_cs_arbiter
//   Lets NumReq byte-stream requesters share one spi_host byte interface.
//   One requester is granted per transaction, round-robin, and its
//   active-low chip select is driven with programmable setup, hold and
//   idle-gap timing around the bytes it streams to the host.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   req_valid_i   per-requester byte available
//   req_data_i    per-requester byte, requester i at [8i+7:8i]
//   req_last_i    per-requester "this byte ends the transaction"
//   req_ready_o   one-cycle pop pulse back to the granted requester
//   host_start_o  to spi_host start_i
//   host_data_o   to spi_host byte_data_i
//   host_next_i   spi_host next_tx_byte_o (level, may stay high for many cycles)
//   host_idle_i   high while spi_host is not shifting
//   cs_no         active-low chip selects, at most one low
//   busy_o        a transaction is in progress
//   grant_o       index of the current / most recent grantee
module spi_cs_arbiter #(
  parameter int  NumReq        = 2,
  parameter int  CsSetupCycles = 4,
  parameter int  CsHoldCycles  = 4,
  parameter int  CsIdleCycles  = 2,
  localparam int GrantW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                host_start_o,
  output logic [7:0]          host_data_o,
  input  logic                host_next_i,
  input  logic                host_idle_i,
  output logic [NumReq-1:0]   cs_no,
  output logic                busy_o,
  output logic [GrantW-1:0]   grant_o
);

  localparam int MaxCycles =
    (CsSetupCycles > CsHoldCycles)
      ? ((CsSetupCycles > CsIdleCycles) ? CsSetupCycles : CsIdleCycles)
      : ((CsHoldCycles  > CsIdleCycles) ? CsHoldCycles  : CsIdleCycles);
  localparam int CntW = (MaxCycles > 0) ? $clog2(MaxCycles + 1) : 1;

  // Terminal count of each timed phase; unused when the phase length is 0.
  localparam logic [CntW-1:0] SetupLast = CntW'((CsSetupCycles > 0) ? CsSetupCycles - 1 : 0);
  localparam logic [CntW-1:0] HoldLast  = CntW'((CsHoldCycles  > 0) ? CsHoldCycles  - 1 : 0);
  localparam logic [CntW-1:0] IdleLast  = CntW'((CsIdleCycles  > 0) ? CsIdleCycles  - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [GrantW-1:0] grant_q, grant_d;
  logic [GrantW-1:0] rr_q, rr_d;
  logic [GrantW-1:0] pick_idx;
  logic              pick_vld;
  logic [CntW-1:0]   cnt_q;
  logic              host_next_p1;
  logic              pop;
  logic              grant_valid;
  logic              grant_last;
  logic [7:0]        req_bytes [NumReq];

  // Phase counter saturates instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [GrantW-1:0] next_ptr(input logic [GrantW-1:0] g);
    if (int'(g) == NumReq - 1) return '0;
    return g + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      req_bytes[i] = req_data_i[8*i +: 8];
    end
  end

  assign grant_valid = req_valid_i[grant_q];
  assign grant_last  = req_last_i[grant_q];

  // Only the rising edge of the host's next-byte level counts as a pop,
  // so a wide host_next_i pulse consumes exactly one byte.
  assign pop = host_next_i & ~host_next_p1;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    logic [GrantW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = GrantW'((int'(rr_q) + i) % NumReq);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // ---- stage p1: state, grant, pointer, counter, host_next history ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      host_next_p1 <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      cnt_q        <= (state_d != state_q) ? '0 : sat_inc(cnt_q);
      host_next_p1 <= host_next_i;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = (CsSetupCycles > 0) ? SETUP : XFER;
        end
      end
      SETUP: begin
        if (cnt_q == SetupLast) state_d = XFER;
      end
      XFER: begin
        // A pop only counts while the grantee is actually offering a byte.
        if (pop && grant_valid && grant_last) state_d = DRAIN;
      end
      DRAIN: begin
        // host_idle_i was forced low by the host at the pop, so the first
        // idle seen here means the last byte has finished shifting.
        if (host_idle_i) begin
          rr_d = next_ptr(grant_q);
          if (CsHoldCycles > 0)      state_d = HOLD;
          else if (CsIdleCycles > 0) state_d = GAP;
          else                       state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == HoldLast) state_d = (CsIdleCycles > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (cnt_q == IdleLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_no        = '1;
    req_ready_o  = '0;
    host_start_o = 1'b0;
    host_data_o  = '0;
    if (state_q inside {SETUP, XFER, DRAIN, HOLD}) cs_no[grant_q] = 1'b0;
    if (state_q == XFER) begin
      host_start_o         = grant_valid;
      host_data_o          = req_bytes[grant_q];
      req_ready_o[grant_q] = pop & grant_valid;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign grant_o = grant_q;

endmodule

// File: doc/spi_cs_arbiter.md
Name: spi_cs_arbiter

Overview:
- Shares the single SPI host byte datapath between NumReq byte-stream requesters, e.g. the CPU TX FIFO and an LCD/DMA streamer.
- Grants one requester per transaction, round-robin, and drives that requester's active-low chip select with programmable setup, hold and idle-gap timing.
- Sits between the requesters and spi_host. It replaces the direct FIFO-to-host hookup and keeps the host's byte interface unchanged.

Parameters:
- NumReq, 2: number of requesters/chip selects (2..8).
- CsSetupCycles, 4: clk cycles CS is low before the first byte is offered (0 = phase skipped).
- CsHoldCycles, 4: clk cycles CS stays low after the last byte finishes shifting (0 = skipped).
- CsIdleCycles, 2: minimum clk cycles all CS are high between transactions (0 = skipped).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  requester i has a byte
- req_data_i  in  NumReq*8  byte of requester i at [8i+7:8i]
- req_last_i  in  NumReq  byte of requester i ends its transaction
- req_ready_o  out  NumReq  one-cycle pop pulse to requester i
- host_start_o  out  1  to spi_host start_i
- host_data_o  out  8  to spi_host byte_data_i
- host_next_i  in  1  from spi_host next_tx_byte_o; level, may be wide
- host_idle_i  in  1  high when spi_host is not shifting
- cs_no  out  NumReq  active-low chip selects
- busy_o  out  1  transaction in progress (state != IDLE)
- grant_o  out  $clog2(NumReq) (min 1)  index of current/last grantee

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: cs_no all 1; host_start_o 0; host_data_o 0; req_ready_o 0; busy_o 0; grant_o 0; RR pointer 0; state IDLE; counters 0.
- Edge detect: register host_next_i. Pop event = host_next_i & ~host_next_q.
- FSM IDLE:
  - If any req_valid_i is set, grant the first valid requester at or after the RR pointer (modulo NumReq) and go to SETUP.
  - Grant is registered. cs_no[grant] goes low in the cycle SETUP is entered.
- FSM SETUP:
  - Count CsSetupCycles cycles with CS low, then go to XFER.
  - If CsSetupCycles is 0, go IDLE -> XFER directly, with CS low on XFER entry.
- FSM XFER:
  - host_start_o = req_valid_i[grant]; host_data_o = req_data_i[grant], combinational from the grantee.
  - On a pop event while host_start_o is 1, pulse req_ready_o[grant] for exactly one cycle. If req_last_i[grant] is 1 at that cycle, go to DRAIN.
  - A pop event while host_start_o is 0 is ignored: no ready pulse.
  - Grantee drops valid mid-transaction: host_start_o = 0, CS stays low, stay in XFER indefinitely (stall; no timeout).
- FSM DRAIN:
  - host_start_o forced 0.
  - Wait until the host has shifted the last byte: host_idle_i = 1 seen on a cycle after the pop. Then go to HOLD.
- FSM HOLD:
  - CS low for CsHoldCycles cycles, then deassert CS.
  - RR pointer <= grant+1 (wrap to 0 after NumReq-1). Go to GAP.
- FSM GAP:
  - All CS high for CsIdleCycles cycles, then go to IDLE. Zero-length phases are skipped.
- Invariants:
  - At most one cs_no bit low at any time.
  - Non-grantees never see req_ready_o.
  - Requests arriving mid-transaction wait. Grants never change inside a transaction.
- Simultaneous requests in IDLE: the RR pointer decides. Requesters with continuous traffic strictly alternate.
- Pop and valid-drop in the same cycle: the pop counts only if valid was high that cycle.
- Reset mid-transaction: all outputs return to reset values immediately and asynchronously. The partial byte in spi_host is not cancelled by this block.
- Counters are sized $clog2(max(CsSetupCycles, CsHoldCycles, CsIdleCycles)+1) and never wrap.

Test Plan:
- Single transaction, defaults: req0 sends 3 bytes (0xA1, 0xA2, 0xA3 with last on the third) -> cs_no[0] low 4 cycles before host_start_o; exactly 3 ready pulses; cs_no[0] high 4 cycles after host_idle_i; busy_o low after 2 GAP cycles.
- Contention: req0 and req1 valid together from reset -> req0 is served first, then req1. With both held continuously over 4 transactions, grant_o = 0, 1, 0, 1; never two CS low; at least 2 all-high cycles between transactions.
- Wide next pulse: host_next_i high for 5 cycles per byte -> one req_ready_o pulse per byte, 1 cycle wide.
- Stall: grantee drops valid after byte 1 for 20 cycles -> host_start_o 0 and CS low throughout; resumes; no extra pops.
- Zero timing: CsSetupCycles = CsHoldCycles = CsIdleCycles = 0 -> CS low on the same cycle host_start_o rises; CS high the cycle after DRAIN completes.
- Reset in XFER: assert rst_ni low mid-byte -> cs_no all 1, host_start_o 0, grant_o 0 asynchronously. After release, a fresh request restarts from SETUP with the RR pointer at 0.
